// File: rtl/alu_issue_stage.sv
// alu_issue_stage: issue register (S1) feeding the ALU plus a tag pipe (S2) aligned with the ALU result.
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   in_valid_i/in_ready_o           decoded-instruction handshake (in_op_i, in_rs_i, in_rt_i, in_imm_i, in_rd_i)
//   flush_i                         kills everything in flight
//   alu_a_o/alu_b_o/alu_ctrl_o      registered ALU operands and control
//   alu_r_i/alu_ovf_i/alu_branch_i  registered ALU result and flags
//   res_*_o                         writeback view of S2, aligned with alu_r_i
//   issue_cnt_o                     wrapping count of accepted legal instructions
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        in_op_i,
    input  logic [DATA_W-1:0] in_rs_i,
    input  logic [DATA_W-1:0] in_rt_i,
    input  logic [IMM_W-1:0]  in_imm_i,
    input  logic [RD_W-1:0]   in_rd_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [2:0]        alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_r_i,
    input  logic              alu_ovf_i,
    input  logic              alu_branch_i,
    output logic              res_valid_o,
    output logic [DATA_W-1:0] res_data_o,
    output logic [RD_W-1:0]   res_rd_o,
    output logic              res_wb_en_o,
    output logic              res_ovf_o,
    output logic              res_br_taken_o,
    output logic              res_illegal_o,
    output logic [CNT_W-1:0]  issue_cnt_o
);
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_OR = 3'd2, OP_XOR = 3'd3;
    localparam logic [2:0] OP_BEQ = 3'd4, OP_ADDI = 3'd5, OP_ORI = 3'd6, OP_XORI = 3'd7;
    typedef enum logic {RUN, BR_WAIT} state_t;
    state_t              state_q, state_d;
    logic [1:0]          wait_q, wait_d;
    logic                s1_valid_q, s1_illegal_q, s2_valid_q, s2_illegal_q;
    logic [2:0]          s1_op_q, s2_op_q;
    logic [RD_W-1:0]     s1_rd_q, s2_rd_q;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q;
    logic [2:0]          alu_ctrl_q;
    logic [CNT_W-1:0]    issue_cnt_q;
    logic                accept, legal;
    logic [2:0]          op, dec_ctrl;
    logic [DATA_W-1:0]   imm_ext, b_sel;
    assign op       = in_op_i[2:0];
    assign legal    = ~in_op_i[3];
    assign accept   = in_valid_i & in_ready_o;
    assign dec_ctrl = (op == OP_ADD || op == OP_ADDI) ? 3'b000 :
                      (op == OP_SUB)                  ? 3'b001 :
                      (op == OP_OR  || op == OP_ORI)  ? 3'b100 :
                      (op == OP_XOR || op == OP_XORI) ? 3'b010 : 3'b011;
    assign imm_ext  = (op == OP_ADDI) ? {{(DATA_W-IMM_W){in_imm_i[IMM_W-1]}}, in_imm_i}
                                      : {{(DATA_W-IMM_W){1'b0}}, in_imm_i};
    // Immediate forms are the only opcodes above BEQ
    assign b_sel    = (op > OP_BEQ) ? imm_ext : in_rt_i;
    // Wait counter is loaded with 2 on BEQ accept; RUN resumes on the edge that takes it to 0
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        in_ready_o = ~reset & ~flush_i & (state_q == RUN);
        if (flush_i) begin
            state_d = RUN;
            wait_d  = 2'd0;
        end else if (state_q == RUN) begin
            if (accept && legal && op == OP_BEQ) begin
                state_d = BR_WAIT;
                wait_d  = 2'd2;
            end
        end else begin
            wait_d  = wait_q - 2'd1;
            state_d = (wait_q == 2'd1) ? RUN : BR_WAIT;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            wait_q       <= 2'd0;
            s1_valid_q   <= 1'b0;
            s1_illegal_q <= 1'b0;
            s1_op_q      <= 3'd0;
            s1_rd_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_illegal_q <= 1'b0;
            s2_op_q      <= 3'd0;
            s2_rd_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= 3'b111;
            issue_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            // accept is already false while flushing, so S1 naturally loads a bubble
            s1_valid_q   <= accept & legal;
            s1_illegal_q <= accept & ~legal;
            alu_ctrl_q   <= (accept & legal) ? dec_ctrl : 3'b111;
            s2_valid_q   <= s1_valid_q & ~flush_i;
            s2_illegal_q <= s1_illegal_q & ~flush_i;
            s2_op_q      <= s1_op_q;
            s2_rd_q      <= s1_rd_q;
            issue_cnt_q  <= issue_cnt_q + CNT_W'(accept & legal);
            if (accept) begin
                alu_a_q <= in_rs_i;
                alu_b_q <= b_sel;
                s1_op_q <= op;
                s1_rd_q <= in_rd_i;
            end
        end
    end
    assign alu_a_o        = alu_a_q;
    assign alu_b_o        = alu_b_q;
    assign alu_ctrl_o     = alu_ctrl_q;
    assign issue_cnt_o    = issue_cnt_q;
    // ALU flags are undefined after its reset, so every qualifier is gated by res_valid
    assign res_valid_o    = s2_valid_q;
    assign res_data_o     = s2_valid_q ? alu_r_i : '0;
    assign res_rd_o       = s2_valid_q ? s2_rd_q : '0;
    assign res_wb_en_o    = s2_valid_q & (s2_op_q != OP_BEQ) & (s2_rd_q != '0);
    assign res_ovf_o      = s2_valid_q & alu_ovf_i &
                            (s2_op_q == OP_ADD || s2_op_q == OP_SUB || s2_op_q == OP_ADDI);
    assign res_br_taken_o = s2_valid_q & alu_branch_i & (s2_op_q == OP_BEQ);
    assign res_illegal_o  = s2_illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed checks of alu_issue_stage against a behavioural registered ALU.
module tb_alu_issue_stage;
    logic        clk = 1'b0, reset = 1'b1;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0;
    logic [3:0]  in_op = 4'd0;
    logic [31:0] in_rs = '0, in_rt = '0;
    logic [15:0] in_imm = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] alu_a, alu_b, alu_r, res_data;
    logic [2:0]  alu_ctrl;
    logic        alu_ovf, alu_branch;
    logic        res_valid, res_wb_en, res_ovf, res_br_taken, res_illegal;
    logic [4:0]  res_rd;
    logic [15:0] issue_cnt;
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op),
        .in_rs_i(in_rs), .in_rt_i(in_rt), .in_imm_i(in_imm), .in_rd_i(in_rd), .flush_i(flush),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_ctrl_o(alu_ctrl), .alu_r_i(alu_r), .alu_ovf_i(alu_ovf),
        .alu_branch_i(alu_branch), .res_valid_o(res_valid), .res_data_o(res_data), .res_rd_o(res_rd),
        .res_wb_en_o(res_wb_en), .res_ovf_o(res_ovf), .res_br_taken_o(res_br_taken),
        .res_illegal_o(res_illegal), .issue_cnt_o(issue_cnt)
    );

    // Registered 32-bit ALU: ovf is the carry out of ADD, the borrow out of SUB
    logic [32:0] add_w, sub_w;
    assign add_w = {1'b0, alu_a} + {1'b0, alu_b};
    assign sub_w = {1'b0, alu_a} - {1'b0, alu_b};
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_r      <= '0;
            alu_ovf    <= 1'b0;
            alu_branch <= 1'b0;
        end else begin
            alu_r      <= (alu_ctrl == 3'b000) ? add_w[31:0] : (alu_ctrl == 3'b001) ? sub_w[31:0] :
                          (alu_ctrl == 3'b100) ? (alu_a | alu_b) : (alu_ctrl == 3'b010) ? (alu_a ^ alu_b) : 32'd0;
            alu_ovf    <= (alu_ctrl == 3'b000) ? add_w[32] : (alu_ctrl == 3'b001) ? sub_w[32] : 1'b0;
            alu_branch <= (alu_ctrl == 3'b011) && (alu_a == alu_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm, input logic [4:0] rd);
        in_valid = v; in_op = op; in_rs = rs; in_rt = rt; in_imm = imm; in_rd = rd;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_ctrl", 32'(alu_ctrl), 32'd7);
        chk("rst_a", alu_a, 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", res_data, 32'd0);
        chk("rst_cnt", 32'(issue_cnt), 32'd0);
        reset = 1'b0;
        #1;
        chk("run_ready", 32'(in_ready), 32'd1);
        // ADD 5+7 -> rd3
        drive(1, 4'd0, 32'd5, 32'd7, 16'd0, 5'd3);
        tick();
        chk("add_a", alu_a, 32'd5);
        chk("add_b", alu_b, 32'd7);
        chk("add_ctrl", 32'(alu_ctrl), 32'd0);
        drive(0, 4'd0, 32'd0, 32'd0, 16'd0, 5'd0);
        tick();
        chk("add_valid", 32'(res_valid), 32'd1);
        chk("add_data", res_data, 32'd12);
        chk("add_wb", 32'(res_wb_en), 32'd1);
        chk("add_rd", 32'(res_rd), 32'd3);
        chk("add_cnt", 32'(issue_cnt), 32'd1);
        tick();
        chk("bubble_valid", 32'(res_valid), 32'd0);
        chk("bubble_data", res_data, 32'd0);
        // SUB 0-1 then ADDI 1+sext(0xFFFF) back to back
        drive(1, 4'd1, 32'd0, 32'd1, 16'd0, 5'd4);
        tick();
        chk("sub_ctrl", 32'(alu_ctrl), 32'd1);
        drive(1, 4'd5, 32'd1, 32'd0, 16'hFFFF, 5'd5);
        tick();
        chk("addi_b", alu_b, 32'hFFFFFFFF);
        chk("sub_data", res_data, 32'hFFFFFFFF);
        chk("sub_ovf", 32'(res_ovf), 32'd1);
        chk("sub_rd", 32'(res_rd), 32'd4);
        drive(0, 4'd0, 32'd0, 32'd0, 16'd0, 5'd0);
        tick();
        chk("addi_data", res_data, 32'd0);
        chk("addi_ovf", 32'(res_ovf), 32'd1);
        chk("addi_rd", 32'(res_rd), 32'd5);
        chk("addi_cnt", 32'(issue_cnt), 32'd3);
        // BEQ 9/9 followed by a held BEQ 9/8
        drive(1, 4'd4, 32'd9, 32'd9, 16'd0, 5'd0);
        tick();
        chk("beq_ctrl", 32'(alu_ctrl), 32'd3);
        chk("beq_ready0", 32'(in_ready), 32'd0);
        drive(1, 4'd4, 32'd9, 32'd8, 16'd0, 5'd0);
        tick();
        chk("beq_ready1", 32'(in_ready), 32'd0);
        chk("beq_valid", 32'(res_valid), 32'd1);
        chk("beq_taken", 32'(res_br_taken), 32'd1);
        chk("beq_wb", 32'(res_wb_en), 32'd0);
        tick();
        chk("beq_ready2", 32'(in_ready), 32'd1);
        chk("beq_cnt", 32'(issue_cnt), 32'd4);
        tick();
        chk("beq2_ready", 32'(in_ready), 32'd0);
        chk("beq2_cnt", 32'(issue_cnt), 32'd5);
        drive(0, 4'd0, 32'd0, 32'd0, 16'd0, 5'd0);
        tick();
        chk("beq2_valid", 32'(res_valid), 32'd1);
        chk("beq2_taken", 32'(res_br_taken), 32'd0);
        tick();
        chk("beq2_ready_back", 32'(in_ready), 32'd1);
        // ORI zero-extends, XORI zero-extends
        drive(1, 4'd6, 32'd0, 32'd0, 16'h8000, 5'd6);
        tick();
        chk("ori_b", alu_b, 32'h00008000);
        drive(1, 4'd7, 32'hFFFF0000, 32'd0, 16'hFFFF, 5'd7);
        tick();
        chk("ori_data", res_data, 32'h00008000);
        chk("ori_ovf", 32'(res_ovf), 32'd0);
        drive(0, 4'd0, 32'd0, 32'd0, 16'd0, 5'd0);
        tick();
        chk("xori_data", res_data, 32'hFFFFFFFF);
        chk("xori_cnt", 32'(issue_cnt), 32'd7);
        // Illegal opcode 12
        drive(1, 4'd12, 32'd3, 32'd4, 16'd0, 5'd9);
        tick();
        chk("ill_ctrl", 32'(alu_ctrl), 32'd7);
        chk("ill_ready", 32'(in_ready), 32'd1);
        drive(0, 4'd0, 32'd0, 32'd0, 16'd0, 5'd0);
        tick();
        chk("ill_pulse", 32'(res_illegal), 32'd1);
        chk("ill_valid", 32'(res_valid), 32'd0);
        chk("ill_wb", 32'(res_wb_en), 32'd0);
        chk("ill_cnt", 32'(issue_cnt), 32'd7);
        tick();
        chk("ill_pulse_end", 32'(res_illegal), 32'd0);
        // Flush while BR_WAIT with ADD in S2
        drive(1, 4'd0, 32'd2, 32'd3, 16'd0, 5'd8);
        tick();
        drive(1, 4'd4, 32'd1, 32'd1, 16'd0, 5'd0);
        tick();
        chk("pre_flush_data", res_data, 32'd5);
        drive(0, 4'd0, 32'd0, 32'd0, 16'd0, 5'd0);
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_valid", 32'(res_valid), 32'd0);
        chk("flush_data", res_data, 32'd0);
        chk("flush_taken", 32'(res_br_taken), 32'd0);
        chk("flush_ctrl", 32'(alu_ctrl), 32'd7);
        chk("flush_ready_after", 32'(in_ready), 32'd1);
        chk("flush_cnt", 32'(issue_cnt), 32'd9);
        // Counter wrap
        drive(1, 4'd0, 32'd0, 32'd0, 16'd0, 5'd0);
        for (int i = 0; i < 65526; i++) tick();
        chk("cnt_max", 32'(issue_cnt), 32'h0000FFFF);
        tick();
        chk("cnt_wrap", 32'(issue_cnt), 32'd0);
        // Reset mid-operation
        drive(1, 4'd0, 32'd1, 32'd1, 16'd0, 5'd1);
        tick();
        reset = 1'b1;
        tick();
        chk("mrst_ready", 32'(in_ready), 32'd0);
        chk("mrst_valid", 32'(res_valid), 32'd0);
        chk("mrst_ctrl", 32'(alu_ctrl), 32'd7);
        chk("mrst_a", alu_a, 32'd0);
        chk("mrst_cnt", 32'(issue_cnt), 32'd0);
        reset = 1'b0;
        drive(0, 4'd0, 32'd0, 32'd0, 16'd0, 5'd0);
        tick();
        chk("mrst_idle_valid", 32'(res_valid), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
